stream_seq_arbiter: RTL

// - Round-robin arbiter + credit scheduler that shares one stream_to_seq instance (and the

---
 rtl/stream_seq_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/stream_seq_arbiter.sv
// -----------------------------------------------------------------------------
// stream_seq_arbiter
//   Shares one stream_to_seq instance (and the sequential consumer behind it)
//   between REQ_NB stream requesters. Arbitration is round robin at packet
//   granularity: once the first beat of a multi-beat packet is accepted, the
//   owner keeps the output until its last beat, so packets never interleave.
//   A beat is issued only while the consumer holds a free credit, which means
//   the sequential side never has to push back.
//
// Ports
//   clk, a_rst_n   clock, asynchronous active-low reset (released synchronously)
//   req_data       per-requester beat data, requester i at [i*IN_NB*WIDTH +: IN_NB*WIDTH]
//   req_last       per-requester "beat is last of packet"
//   req_vld        per-requester valid
//   req_rdy        per-requester ready, at most one bit set
//   out_data       registered beat towards stream_to_seq in_data
//   out_id         requester index of out_data
//   out_vld        towards stream_to_seq in_vld
//   out_rdy        from stream_to_seq in_rdy
//   credit_inc     one-cycle pulse, consumer freed one beat slot
//   credit_cnt     current credit count
//   busy           packet in progress or output register occupied
// -----------------------------------------------------------------------------
module stream_seq_arbiter #(
  parameter int WIDTH     = 8,
  parameter int IN_NB     = 8,
  parameter int REQ_NB    = 4,
  parameter int CREDIT_NB = 4,
  localparam int REQ_W    = $clog2(REQ_NB),
  localparam int CREDIT_W = $clog2(CREDIT_NB + 1)
) (
  input  logic                          clk,
  input  logic                          a_rst_n,
  input  logic [REQ_NB*IN_NB*WIDTH-1:0] req_data,
  input  logic [REQ_NB-1:0]             req_last,
  input  logic [REQ_NB-1:0]             req_vld,
  output logic [REQ_NB-1:0]             req_rdy,
  output logic [IN_NB*WIDTH-1:0]        out_data,
  output logic [REQ_W-1:0]              out_id,
  output logic                          out_vld,
  input  logic                          out_rdy,
  input  logic                          credit_inc,
  output logic [CREDIT_W-1:0]           credit_cnt,
  output logic                          busy
);

  localparam int                  BEAT_W     = IN_NB * WIDTH;
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(CREDIT_NB);
  localparam logic [REQ_W-1:0]    LAST_ID    = REQ_W'(REQ_NB - 1);
  localparam logic [REQ_W:0]      REQ_NB_V   = (REQ_W + 1)'(REQ_NB);

  typedef enum logic {
    ST_IDLE,
    ST_LOCK
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [REQ_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
  logic [REQ_W-1:0]     r_lock_id, w_lock_id_nxt;
  logic [BEAT_W-1:0]    r_out_data;
  logic [REQ_W-1:0]     r_out_id;
  logic                 r_out_vld;
  logic [CREDIT_W-1:0]  r_credit_cnt;

  logic                 w_slot_free;
  logic                 w_can_issue;
  logic                 w_rr_vld;
  logic [REQ_W-1:0]     w_rr_id;
  logic [REQ_W:0]       w_rr_idx;
  logic                 w_sel_en;
  logic [REQ_W-1:0]     w_sel_id;
  logic [BEAT_W-1:0]    w_sel_data;
  logic                 w_sel_last;
  logic                 w_accept;

  function automatic logic [REQ_W-1:0] wrap_inc(input logic [REQ_W-1:0] id);
    return (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

  // A beat may enter the output register when it is empty or draining this
  // cycle, and only while the consumer still has room for it.
  assign w_slot_free = !r_out_vld || out_rdy;
  assign w_can_issue = w_slot_free && (r_credit_cnt != '0);

  // Round-robin search starting at r_rr_ptr. Candidates are visited from the
  // farthest to the nearest so the nearest valid requester is the one left.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_rr_vld = 1'b0;
    w_rr_id  = '0;
    w_rr_idx = '0;
    for (int k = REQ_NB - 1; k >= 0; k--) begin
      w_rr_idx = {1'b0, r_rr_ptr} + (REQ_W + 1)'(k);
      if (w_rr_idx >= REQ_NB_V) w_rr_idx = w_rr_idx - REQ_NB_V;
      if (req_vld[w_rr_idx[REQ_W-1:0]]) begin
        w_rr_vld = 1'b1;
        w_rr_id  = w_rr_idx[REQ_W-1:0];
      end
    end
  end

  // In LOCK only the owner is considered, whether or not it is valid, so
  // req_rdy never depends on other requesters' valids mid-packet.
  assign w_sel_en   = (r_state == ST_LOCK) ? 1'b1 : w_rr_vld;
  assign w_sel_id   = (r_state == ST_LOCK) ? r_lock_id : w_rr_id;
  assign w_sel_last = req_last[w_sel_id];
  assign w_accept   = w_sel_en && w_can_issue && req_vld[w_sel_id];

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < REQ_NB; i++) begin
      if (w_sel_id == REQ_W'(i)) w_sel_data = req_data[i*BEAT_W +: BEAT_W];
    end
  end

  always_comb begin
    req_rdy = '0;
    for (int i = 0; i < REQ_NB; i++) begin
      req_rdy[i] = w_sel_en && w_can_issue && (w_sel_id == REQ_W'(i));
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_lock_id_nxt = r_lock_id;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_sel_last) begin
            w_rr_ptr_nxt = wrap_inc(w_sel_id);
          end else begin
            w_state_nxt   = ST_LOCK;
            w_lock_id_nxt = w_sel_id;
          end
        end
      end
      ST_LOCK: begin
        if (w_accept && w_sel_last) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = wrap_inc(r_lock_id);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= '0;
      r_lock_id <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_lock_id <= w_lock_id_nxt;
    end
  end

  // Output stage: loads on accept, empties when drained with nothing new,
  // and otherwise holds (out_vld && !out_rdy blocks any accept).
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_id   <= '0;
    end else if (w_accept) begin
      r_out_vld  <= 1'b1;
      r_out_data <= w_sel_data;
      r_out_id   <= w_sel_id;
    end else if (out_rdy) begin
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_id   <= '0;
    end
  end

  // Credits: an accept consumes one, a credit_inc pulse returns one; both in
  // the same cycle cancel. Accept is impossible at zero, so no underflow.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_credit_cnt <= CREDIT_MAX;
    end else begin
      case ({w_accept, credit_inc})
        2'b10:   r_credit_cnt <= r_credit_cnt - 1'b1;
        2'b01:   if (r_credit_cnt != CREDIT_MAX) r_credit_cnt <= r_credit_cnt + 1'b1;
        default: r_credit_cnt <= r_credit_cnt;
      endcase
    end
  end

  assign out_data   = r_out_data;
  assign out_id     = r_out_id;
  assign out_vld    = r_out_vld;
  assign credit_cnt = r_credit_cnt;
  assign busy       = (r_state == ST_LOCK) || r_out_vld;

`ifndef SYNTHESIS
  a_rdy_onehot0 : assert property (@(posedge clk) disable iff (!a_rst_n)
    $onehot0(req_rdy));

  a_out_stable : assert property (@(posedge clk) disable iff (!a_rst_n)
    (r_out_vld && !out_rdy) |=> ($stable(r_out_data) && $stable(r_out_id)));

  a_credit_ovf : assert property (@(posedge clk) disable iff (!a_rst_n)
    !(credit_inc && !w_accept && (r_credit_cnt == CREDIT_MAX)))
    else $fatal(1, "stream_seq_arbiter: credit_inc with credits already at maximum");
`endif

endmodule
